// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared FSM encodings and sizing helpers for the loadable instruction memory
package instr_mem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    // A single-byte word still needs a 1-bit counter so the port stays legal.
    function automatic int byte_cnt_width(input int data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
    endfunction

endpackage

// File: rtl/instr_mem_loadable_packer.sv
// rtl/instr_mem_loadable_packer.sv - byte_word_packer: MSB-first shift-register word assembler
module byte_word_packer
    import instr_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_full_o
);

    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int CNT_W = byte_cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    // Flags the byte that completes the word; the full word is in word_q after this edge.
    assign word_full_o = byte_valid_i && (cnt_q == LAST_CNT);
    assign word_o      = word_q;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (byte_valid_i) begin
            word_d = (word_q << 8) | DATA_WIDTH'(byte_i);
            cnt_d  = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - run-time loadable instruction memory; INSTR_MEM_PARITY_EN adds per-word parity
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_err,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [7:0]            load_byte,
    output logic                  load_done,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH:0]   word_cnt_inc;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  fetch_valid_q;
    logic [DATA_WIDTH-1:0] fetch_data_q;

    logic                  in_idle;
    logic                  start_accept;
    logic                  fetch_accept;
    logic                  byte_accept;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] pack_word;
    logic                  pack_full;

    assign in_idle      = (state_q == ST_IDLE);
    assign start_accept = in_idle && load_start;
    // Held low during reset so every output reads 0 while rst is asserted.
    assign fetch_ready  = in_idle && !rst;
    assign fetch_accept = fetch_req && fetch_ready;
    assign load_ready   = (state_q == ST_LOAD);
    assign byte_accept  = load_valid && load_ready;
    assign load_done    = (state_q == ST_DONE);
    assign busy         = !in_idle;
    assign write_en     = (state_q == ST_WRITE);
    assign word_cnt_inc = word_cnt_q + (ADDR_WIDTH + 1)'(1);
    assign write_addr   = base_q + word_cnt_q[ADDR_WIDTH-1:0];
    assign fetch_valid  = fetch_valid_q;
    assign fetch_data   = fetch_data_q;

    byte_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_accept),
        .byte_valid_i (byte_accept),
        .byte_i       (load_byte),
        .word_o       (pack_word),
        .word_full_o  (pack_full)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    base_d     = load_base;
                    len_d      = load_len;
                    word_cnt_d = '0;
                    state_d    = (load_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (pack_full) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_inc;
                state_d    = (word_cnt_inc == len_q) ? ST_DONE : ST_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Array contents survive reset so a reset mid-load keeps already written words.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[write_addr] <= pack_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            fetch_valid_q <= fetch_accept;
            if (fetch_accept) begin
                fetch_data_q <= mem_q[fetch_addr];
            end
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic par_q [DEPTH];
    logic fetch_err_q;

    always_ff @(posedge clk) begin
        if (write_en) begin
            par_q[write_addr] <= ^pack_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= fetch_accept && ((^mem_q[fetch_addr]) != par_q[fetch_addr]);
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - directed self-checking bench for instr_mem_loadable
module tb_instr_mem_loadable;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [8:0]  fetch_addr = '0;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_err;
    logic        load_start = 1'b0;
    logic [8:0]  load_base = '0;
    logic [9:0]  load_len = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [7:0]  load_byte = '0;
    logic        load_done;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    logic [7:0] ld_bytes [16];

    instr_mem_loadable #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_err   (fetch_err),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_len    (load_len),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_byte   (load_byte),
        .load_done   (load_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Advance one edge and sample 1ns later; tally WRITE cycles and done pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (busy && !load_ready && !load_done) wr_cnt++;
        if (load_done) done_cnt++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},        {31'd0, busy},        32'd0);
        check({tag, "_fetch_ready"}, {31'd0, fetch_ready}, 32'd0);
        check({tag, "_fetch_valid"}, {31'd0, fetch_valid}, 32'd0);
        check({tag, "_fetch_data"},  fetch_data,           32'd0);
        check({tag, "_fetch_err"},   {31'd0, fetch_err},   32'd0);
        check({tag, "_load_ready"},  {31'd0, load_ready},  32'd0);
        check({tag, "_load_done"},   {31'd0, load_done},   32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit rdy;
        bit ok;
        if (gap) begin
            load_valid = 1'b0;
            tick();
        end
        load_valid = 1'b1;
        load_byte  = b;
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            rdy = load_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        load_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && busy; n++) tick();
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic start_load(input logic [8:0] base, input logic [9:0] len);
        wr_cnt     = 0;
        done_cnt   = 0;
        load_start = 1'b1;
        load_base  = base;
        load_len   = len;
        tick();
        load_start = 1'b0;
        load_base  = ~base;
        load_len   = 10'd3;
    endtask

    task automatic run_load(input string tag, input logic [8:0] base, input logic [9:0] len,
                            input bit gap);
        start_load(base, len);
        for (int i = 0; i < 4 * int'(len); i++) send_byte(ld_bytes[i], gap);
        wait_idle();
        check({tag, "_done_pulses"},  done_cnt, 32'd1);
        check({tag, "_write_cycles"}, wr_cnt,   32'(len));
    endtask

    task automatic fetch_one(input string tag, input logic [8:0] a, input logic [31:0] exp);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req  = 1'b0;
        check({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
        check({tag, "_data"},  fetch_data,           exp);
        check({tag, "_err"},   {31'd0, fetch_err},   32'd0);
    endtask

    task automatic set_bytes(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [95:0] all;
        all = {w0, w1, w2};
        for (int i = 0; i < 12; i++) ld_bytes[i] = all[95 - 8 * i -: 8];
    endtask

    initial begin
        #2 rst = 1'b1;
        #2 check_all_zero("reset");
        #8 rst = 1'b0;
        tick();
        check("after_reset_ready", {31'd0, fetch_ready}, 32'd1);

        // Basic two-word load and back-to-back fetch.
        set_bytes(32'h04000000, 32'h0C00002F, 32'h0);
        run_load("load2", 9'd0, 10'd2, 1'b0);
        fetch_req  = 1'b1;
        fetch_addr = 9'd0;
        tick();
        fetch_addr = 9'd1;
        check("b2b_f0_valid", {31'd0, fetch_valid}, 32'd1);
        check("b2b_f0_data",  fetch_data, 32'h04000000);
        tick();
        fetch_req = 1'b0;
        check("b2b_f1_valid", {31'd0, fetch_valid}, 32'd1);
        check("b2b_f1_data",  fetch_data, 32'h0C00002F);
        tick();
        check("idle_valid_low", {31'd0, fetch_valid}, 32'd0);
        check("idle_data_hold", fetch_data, 32'h0C00002F);

        // Gapped load_valid; WRITE-cycle backpressure is covered by the no-gap loads.
        set_bytes(32'h11223344, 32'h55667788, 32'h99AABBCC);
        run_load("gapped", 9'd2, 10'd3, 1'b1);
        fetch_one("g2", 9'd2, 32'h11223344);
        fetch_one("g3", 9'd3, 32'h55667788);
        fetch_one("g4", 9'd4, 32'h99AABBCC);

        // Address wrap at the top of the array.
        set_bytes(32'hDEADBEEF, 32'hCAFEF00D, 32'h0);
        run_load("wrap", 9'd511, 10'd2, 1'b0);
        fetch_one("w511", 9'd511, 32'hDEADBEEF);
        fetch_one("w0",   9'd0,   32'hCAFEF00D);
        fetch_one("w1",   9'd1,   32'h0C00002F);

        // Zero-length load completes immediately and writes nothing.
        start_load(9'd0, 10'd0);
        check("len0_done", {31'd0, load_done}, 32'd1);
        tick();
        check("len0_done_drop", {31'd0, load_done}, 32'd0);
        check("len0_idle",      {31'd0, busy},      32'd0);
        fetch_one("len0_w0", 9'd0, 32'hCAFEF00D);

        // Fetch in the same cycle as load_start returns pre-load contents.
        fetch_req  = 1'b1;
        fetch_addr = 9'd0;
        set_bytes(32'h01020304, 32'h0, 32'h0);
        start_load(9'd0, 10'd1);
        fetch_req = 1'b0;
        check("same_cyc_valid", {31'd0, fetch_valid}, 32'd1);
        check("same_cyc_data",  fetch_data, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) send_byte(ld_bytes[i], 1'b0);
        wait_idle();
        fetch_one("same_cyc_new", 9'd0, 32'h01020304);

        // Fetch during LOAD is dropped; reset after 5 of 8 bytes.
        set_bytes(32'hA1A2A3A4, 32'hB1B2B3B4, 32'h0);
        start_load(9'd0, 10'd2);
        fetch_req  = 1'b1;
        fetch_addr = 9'd1;
        check("load_not_ready", {31'd0, fetch_ready}, 32'd0);
        tick();
        fetch_req = 1'b0;
        check("load_fetch_dropped", {31'd0, fetch_valid}, 32'd0);
        for (int i = 0; i < 5; i++) send_byte(ld_bytes[i], 1'b0);
        check("midload_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        #3 rst = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, fetch_ready}, 32'd1);
        check("post_rst_idle",  {31'd0, busy},        32'd0);
        fetch_one("rst_w0", 9'd0, 32'hA1A2A3A4);
        fetch_one("rst_w1", 9'd1, 32'h0C00002F);

`ifdef INSTR_MEM_PARITY_EN
        dut.mem_q[1][5] = ~dut.mem_q[1][5];
        fetch_req  = 1'b1;
        fetch_addr = 9'd1;
        tick();
        fetch_req = 1'b0;
        check("par_bad_err",  {31'd0, fetch_err}, 32'd1);
        check("par_bad_data", fetch_data, 32'h0C00000F);
        fetch_one("par_good", 9'd0, 32'hA1A2A3A4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
